case_match_engine: RTL and testbench

//  Parametrised pattern matcher that models case / casez / casex selection

---
 rtl/case_match_pkg.sv | 26 ++
 rtl/case_match_prio_enc.sv | 24 ++
 rtl/case_match_engine.sv | 138 +++++++++++++
 tb/tb_case_match_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/case_match_pkg.sv
// Shared mode encodings and the per-bit match rule used by the case/casez/casex
// pattern matcher.
package case_match_pkg;

  localparam logic [1:0] MODE_CASE  = 2'd0;
  localparam logic [1:0] MODE_CASEZ = 2'd1;
  localparam logic [1:0] MODE_CASEX = 2'd2;

  // Reserved mode 3 falls through to the exact (===-like) CASE rule.
  function automatic logic bit_match(
    input logic [1:0] mode,
    input logic       sel,
    input logic       xm,
    input logic       val,
    input logic       msk
  );
    logic eq;
    eq = (sel == val);
    case (mode)
      MODE_CASEZ: return msk | (~xm & eq);
      MODE_CASEX: return msk | xm | eq;
      default:    return (xm == msk) & (xm | eq);
    endcase
  endfunction

endpackage

// File: rtl/case_match_prio_enc.sv
// Lowest-index priority encoder over the registered hit vector; also flags
// when more than one entry hit.
module case_match_prio_enc #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         vec,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     multi
);

  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    hit   = |vec;
    multi = |(vec & (vec - DEPTH'(1)));
    idx   = '0;
    // Scan downward so the lowest set index is the last assignment.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/case_match_engine.sv
// Programmable case/casez/casex table matcher: valid/ready input, two-stage
// pipeline (hit vector, then priority result), per-entry saturating hit counters.
module case_match_engine
  import case_match_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic                     cfg_en,
  input  logic [WIDTH-1:0]         cfg_value,
  input  logic [WIDTH-1:0]         cfg_mask,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_sel,
  input  logic [WIDTH-1:0]         in_xmask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_hit,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  output logic                     out_multi,
  input  logic [$clog2(DEPTH)-1:0] cnt_rd_idx,
  output logic [CNT_W-1:0]         cnt_rd_data,
  input  logic                     cnt_clr
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             en_reg    [DEPTH];
  logic [WIDTH-1:0] value_reg [DEPTH];
  logic [WIDTH-1:0] mask_reg  [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        en_reg[i]    <= 1'b0;
        value_reg[i] <= '0;
        mask_reg[i]  <= '0;
      end
    end else if (cfg_we) begin
      en_reg[cfg_idx]    <= cfg_en;
      value_reg[cfg_idx] <= cfg_value;
      mask_reg[cfg_idx]  <= cfg_mask;
    end
  end

  // Compare against the current (pre-write) table; mode is consumed here.
  logic [DEPTH-1:0] match_vec;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic entry_hit;
    always_comb begin
      entry_hit = en_reg[gi];
      for (int b = 0; b < WIDTH; b++) begin
        entry_hit = entry_hit &
                    bit_match(mode, in_sel[b], in_xmask[b], value_reg[gi][b], mask_reg[gi][b]);
      end
    end
    assign match_vec[gi] = entry_hit;
  end

  logic             s1_valid_reg;
  logic [DEPTH-1:0] s1_hits_reg;
  logic             out_valid_reg;
  logic             out_hit_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic             out_multi_reg;
  logic             advance;

  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_hits_reg  <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      s1_hits_reg  <= match_vec;
    end
  end

  logic             enc_hit;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_multi;

  case_match_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
    .vec   (s1_hits_reg),
    .hit   (enc_hit),
    .idx   (enc_idx),
    .multi (enc_multi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_hit_reg   <= 1'b0;
      out_idx_reg   <= '0;
      out_multi_reg <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= s1_valid_reg;
      out_hit_reg   <= s1_valid_reg & enc_hit;
      out_idx_reg   <= s1_valid_reg ? enc_idx : '0;
      out_multi_reg <= s1_valid_reg & enc_multi;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_hit   = out_hit_reg;
  assign out_idx   = out_idx_reg;
  assign out_multi = out_multi_reg;

  logic consume_hit;
  logic [DEPTH-1:0][CNT_W-1:0] cnt_all;

  assign consume_hit = out_valid_reg && out_ready && out_hit_reg;

  // Clear has priority over a same-cycle increment; counters stick at all-ones.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr) begin
        cnt_reg <= '0;
      end else if (consume_hit && out_idx_reg == IDX_W'(gi) && cnt_reg != {CNT_W{1'b1}}) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
    assign cnt_all[gi] = cnt_reg;
  end

  assign cnt_rd_data = cnt_all[cnt_rd_idx];

endmodule

// File: tb/tb_case_match_engine.sv
// Directed bench for case_match_engine: table-driven match vectors plus
// hand-written stall, counter, write-collision and reset sequences.
module tb_case_match_engine;

  localparam logic [1:0] M_CASE  = 2'd0;
  localparam logic [1:0] M_CASEZ = 2'd1;
  localparam logic [1:0] M_CASEX = 2'd2;
  localparam logic [1:0] M_RSVD  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic       cfg_en = 1'b0;
  logic [3:0] cfg_value = '0;
  logic [3:0] cfg_mask = '0;
  logic [1:0] mode = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_sel = '0;
  logic [3:0] in_xmask = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_hit;
  logic [1:0] out_idx;
  logic       out_multi;
  logic [1:0] cnt_rd_idx = '0;
  logic [7:0] cnt_rd_data;
  logic       cnt_clr = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  case_match_engine #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_value(cfg_value), .cfg_mask(cfg_mask), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_xmask(in_xmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_idx(out_idx), .out_multi(out_multi),
    .cnt_rd_idx(cnt_rd_idx), .cnt_rd_data(cnt_rd_data), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_entry(input int idx, input bit en, input logic [3:0] val, input logic [3:0] msk);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_en = en; cfg_value = val; cfg_mask = msk;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic read_cnt(input int idx, output int val);
    cnt_rd_idx = idx[1:0];
    #1;
    val = int'(cnt_rd_data);
  endtask

  // One isolated transaction: accept, expect result exactly one edge later, consume.
  task automatic run_one(input string name, input logic [1:0] md, input logic [3:0] s,
                         input logic [3:0] x, input bit eh, input int ei, input bit em);
    int wc;
    mode = md; in_sel = s; in_xmask = x; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    wc = 0;
    while (!in_ready && wc < 10) begin @(posedge clk); #2; wc++; end
    chk({name, "/accept"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wc = 0;
    while (!out_valid && wc < 10) begin @(posedge clk); #1; wc++; end
    chk({name, "/latency"}, wc, 1);
    chk({name, "/hit"}, int'(out_hit), int'(eh));
    chk({name, "/idx"}, int'(out_idx), ei);
    chk({name, "/multi"}, int'(out_multi), int'(em));
    $display("txn %s mode=%0d sel=%b xm=%b -> hit=%0d idx=%0d multi=%0d", name, md, s, x,
             out_hit, out_idx, out_multi);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string      name;
    bit         do_cfg;
    int         ci;
    bit         cen;
    logic [3:0] cv;
    logic [3:0] cm;
    logic [1:0] md;
    logic [3:0] sel;
    logic [3:0] xm;
    bit         eh;
    int         ei;
    bit         em;
  } vec_t;

  vec_t vecs[13];
  bit   exp_hit[8];
  int   exp_idx[8];

  initial begin
    int v;
    int n_in, n_out, first_drop;

    vecs[0]  = '{"t1_case",      0, 0, 0, 4'h0, 4'h0, M_CASE,  4'b0001, 4'b0000, 1, 1, 0};
    vecs[1]  = '{"t2_case_x",    0, 0, 0, 4'h0, 4'h0, M_CASE,  4'b0000, 4'b0001, 1, 2, 0};
    vecs[2]  = '{"t2_casez",     0, 0, 0, 4'h0, 4'h0, M_CASEZ, 4'b0000, 4'b0001, 1, 2, 1};
    vecs[3]  = '{"casez_no_e2",  1, 2, 0, 4'h0, 4'h1, M_CASEZ, 4'b0000, 4'b0001, 1, 3, 0};
    vecs[4]  = '{"casez_no_e3",  1, 3, 0, 4'h0, 4'hf, M_CASEZ, 4'b0000, 4'b0001, 0, 0, 0};
    vecs[5]  = '{"t3_casex",     1, 2, 1, 4'h0, 4'h1, M_CASEX, 4'b0000, 4'b0000, 1, 0, 1};
    vecs[6]  = '{"t3_casex_ne0", 1, 0, 0, 4'h0, 4'h0, M_CASEX, 4'b0000, 4'b0000, 1, 2, 0};
    vecs[7]  = '{"casex_e3on",   1, 3, 1, 4'h0, 4'hf, M_CASEX, 4'b0000, 4'b0000, 1, 2, 1};
    vecs[8]  = '{"rsvd_as_case", 0, 0, 0, 4'h0, 4'h0, M_RSVD,  4'b0001, 4'b0000, 1, 1, 0};
    vecs[9]  = '{"casex_mixed",  0, 0, 0, 4'h0, 4'h0, M_CASEX, 4'b1010, 4'b0101, 1, 3, 0};
    vecs[10] = '{"case_allx",    0, 0, 0, 4'h0, 4'h0, M_CASE,  4'b0000, 4'b1111, 1, 3, 0};
    vecs[11] = '{"casex_x0",     0, 0, 0, 4'h0, 4'h0, M_CASEX, 4'b0000, 4'b0001, 1, 1, 1};
    vecs[12] = '{"case_e0back",  1, 0, 1, 4'h0, 4'h0, M_CASE,  4'b0000, 4'b0000, 1, 0, 0};

    exp_hit = '{1, 1, 0, 0, 0, 0, 0, 0};
    exp_idx = '{0, 1, 0, 0, 0, 0, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst/in_ready", int'(in_ready), 1);
    chk("rst/out_valid", int'(out_valid), 0);
    chk("rst/out_hit", int'(out_hit), 0);
    chk("rst/out_idx", int'(out_idx), 0);
    chk("rst/out_multi", int'(out_multi), 0);
    for (int i = 0; i < 4; i++) begin
      read_cnt(i, v);
      chk($sformatf("rst/cnt%0d", i), v, 0);
    end
    @(posedge clk); #1;
    run_one("rst_table_empty", M_CASEX, 4'b0000, 4'b0000, 0, 0, 0);

    write_entry(0, 1, 4'b0000, 4'b0000);
    write_entry(1, 1, 4'b0001, 4'b0000);
    write_entry(2, 1, 4'b0000, 4'b0001);
    write_entry(3, 1, 4'b0000, 4'b1111);

    for (int k = 0; k < 13; k++) begin
      if (vecs[k].do_cfg) write_entry(vecs[k].ci, vecs[k].cen, vecs[k].cv, vecs[k].cm);
      run_one(vecs[k].name, vecs[k].md, vecs[k].sel, vecs[k].xm, vecs[k].eh, vecs[k].ei, vecs[k].em);
    end

    // T4: stream of 8 with out_ready low for the first 4 cycles
    n_in = 0; n_out = 0; first_drop = -1;
    for (int c = 0; c < 40 && n_out < 8; c++) begin
      out_ready = (c >= 4);
      mode = M_CASE; in_xmask = 4'b0000;
      in_valid = (n_in < 8);
      in_sel = n_in[3:0];
      #1;
      if (in_valid && !in_ready && first_drop < 0) first_drop = n_in;
      if (out_valid) begin
        chk($sformatf("stream%0d/hit", n_out), int'(out_hit), int'(exp_hit[n_out]));
        chk($sformatf("stream%0d/idx", n_out), int'(out_idx), exp_idx[n_out]);
        if (out_ready) begin
          $display("txn stream%0d -> hit=%0d idx=%0d", n_out, out_hit, out_idx);
          n_out++;
        end
      end
      if (in_valid && in_ready) n_in++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream/accepts_before_stall", first_drop, 2);
    chk("stream/results", n_out, 8);

    // T5: saturation then clear-wins
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    read_cnt(1, v);
    chk("cnt/cleared", v, 0);
    mode = M_CASE; in_sel = 4'b0001; in_xmask = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_cnt(1, v);
    chk("cnt/saturate", v, 255);
    read_cnt(0, v);
    chk("cnt/other_untouched", v, 0);
    $display("txn 300 hits on e1 -> cnt1=255 expected");

    in_sel = 4'b0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clrhit/out_valid", int'(out_valid), 1);
    chk("clrhit/out_hit", int'(out_hit), 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    read_cnt(1, v);
    chk("clrhit/cnt1", v, 0);
    run_one("after_clr_hit", M_CASE, 4'b0001, 4'b0000, 1, 1, 0);
    read_cnt(1, v);
    chk("after_clr/cnt1", v, 1);

    // Table write in the same cycle as an accept uses the old table
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b0; cfg_value = 4'b0001; cfg_mask = 4'b0000;
    mode = M_CASE; in_sel = 4'b0001; in_xmask = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_collide/out_valid", int'(out_valid), 1);
    chk("wr_collide/hit_old", int'(out_hit), 1);
    chk("wr_collide/idx_old", int'(out_idx), 1);
    $display("txn write+accept same cycle -> hit=%0d idx=%0d", out_hit, out_idx);
    @(posedge clk); #1;
    run_one("wr_collide_new", M_CASE, 4'b0001, 4'b0000, 0, 0, 0);
    write_entry(1, 1, 4'b0001, 4'b0000);

    // T6: reset with two transactions in flight
    mode = M_CASE; in_sel = 4'b0001; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_sel = 4'b0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight/out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst/out_valid", int'(out_valid), 0);
    chk("midrst/in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_cnt(i, v);
      chk($sformatf("midrst/cnt%0d", i), v, 0);
    end
    @(posedge clk); #1;
    chk("midrst/no_ghost", int'(out_valid), 0);
    run_one("t6_t1_again", M_CASE, 4'b0001, 4'b0000, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
